// File: rtl/reg_wb_unit.sv
// rtl/reg_wb_unit.sv - in-order writeback queue from ALU/LSU to the register-file rd port
// Optional forwarding lookup enabled by WB_BYPASS_EN.
module reg_wb_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         lsu_valid,
    output logic                         lsu_ready,
    input  logic [ADDR_W-1:0]            lsu_addr,
    input  logic [XLEN-1:0]              lsu_data,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [ADDR_W-1:0]            alu_addr,
    input  logic [XLEN-1:0]              alu_data,
    output logic                         rd_web,
    output logic [ADDR_W-1:0]            rd_addr,
    output logic [XLEN-1:0]              rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]            fwd_addr,
    output logic                         fwd_hit,
    output logic [XLEN-1:0]              fwd_data
`endif
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] L_LSU_MAX = CW'(DEPTH-1);
    localparam logic [CW-1:0] L_ALU_MAX = CW'(DEPTH-2);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [XLEN-1:0]   r_data [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;

    logic              w_lsu_push;
    logic              w_alu_push;
    logic              w_pop;
    logic [PW-1:0]     w_alu_idx;
    logic [PW-1:0]     w_wptr_n;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign lsu_ready = !flush && (r_count <= L_LSU_MAX);
    assign alu_ready = !flush && (r_count <= L_ALU_MAX);

    // x0 handshakes complete but never occupy a slot
    assign w_lsu_push = lsu_valid && lsu_ready && (lsu_addr != '0);
    assign w_alu_push = alu_valid && alu_ready && (alu_addr != '0);
    assign w_pop      = (r_count != '0);

    // LSU is older, so it takes the first free slot
    assign w_alu_idx  = w_lsu_push ? f_inc(r_wptr) : r_wptr;
    assign w_wptr_n   = w_alu_push ? f_inc(w_alu_idx) : w_alu_idx;

    assign rd_web  = w_pop;
    assign rd_addr = w_pop ? r_addr[r_rptr] : '0;
    assign rd_data = w_pop ? r_data[r_rptr] : '0;
    assign count   = r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_lsu_push) begin
                r_addr[r_wptr] <= lsu_addr;
                r_data[r_wptr] <= lsu_data;
            end
            if (w_alu_push) begin
                r_addr[w_alu_idx] <= alu_addr;
                r_data[w_alu_idx] <= alu_data;
            end
            r_wptr  <= w_wptr_n;
            r_rptr  <= w_pop ? f_inc(r_rptr) : r_rptr;
            r_count <= r_count + CW'(w_lsu_push) + CW'(w_alu_push) - CW'(w_pop);
        end
    end

`ifdef WB_BYPASS_EN
    // Scan oldest to youngest so the last match is the youngest
    always_comb begin
        logic [PW-1:0] v_idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        v_idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            v_idx = PW'((int'(r_rptr) + k) % DEPTH);
            if (k < int'(r_count) && fwd_addr != '0 && r_addr[v_idx] == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = r_data[v_idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_wb_unit.sv
// tb/tb_reg_wb_unit.sv - directed self-checking bench for reg_wb_unit
module tb_reg_wb_unit;

    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic        lsu_valid, lsu_ready, alu_valid, alu_ready;
    logic [4:0]  lsu_addr, alu_addr, rd_addr;
    logic [31:0] lsu_data, alu_data, rd_data;
    logic        rd_web;
    logic [2:0]  count;
`ifdef WB_BYPASS_EN
    logic [4:0]  fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_wb_unit #(.XLEN(32), .ADDR_W(5), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .rd_web(rd_web), .rd_addr(rd_addr), .rd_data(rd_data), .count(count)
`ifdef WB_BYPASS_EN
        , .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic web, input logic [4:0] a,
                          input logic [31:0] d, input logic [2:0] c);
        chk({tag, "_web"}, 64'(rd_web), 64'(web));
        chk({tag, "_addr"}, 64'(rd_addr), 64'(a));
        chk({tag, "_data"}, 64'(rd_data), 64'(d));
        chk({tag, "_count"}, 64'(count), 64'(c));
    endtask

    task automatic drive(input logic lv, input logic [4:0] la, input logic [31:0] ld,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad);
        lsu_valid = lv; lsu_addr = la; lsu_data = ld;
        alu_valid = av; alu_addr = aa; alu_data = ad;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
`ifdef WB_BYPASS_EN
        fwd_addr = 5'd0;
`endif
        tick(); tick();
        rd_chk("reset", 0, 0, 0, 0);
        chk("reset_lsu_ready", 64'(lsu_ready), 64'd1);
        chk("reset_alu_ready", 64'(alu_ready), 64'd1);
        rst_n = 1'b1;

        // single ALU write
        drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        rd_chk("alu_x5", 1, 5'd5, 32'hDEADBEEF, 3'd1);
        tick();
        rd_chk("alu_x5_done", 0, 0, 0, 0);

        // same-cycle LSU and ALU to x3: LSU retires first
        drive(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        rd_chk("pair_1", 1, 5'd3, 32'h11, 3'd2);
        tick();
        rd_chk("pair_2", 1, 5'd3, 32'h22, 3'd1);
        tick();
        rd_chk("pair_3", 0, 0, 0, 0);

        // both channels valid continuously: 0 -> 2 -> 3 -> 3
        drive(1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2);
        tick();
        rd_chk("stream_1", 1, 5'd1, 32'hA1, 3'd2);
        chk("stream_1_alu_ready", 64'(alu_ready), 64'd1);
        tick();
        rd_chk("stream_2", 1, 5'd2, 32'hB2, 3'd3);
        chk("stream_2_alu_ready", 64'(alu_ready), 64'd0);
        chk("stream_2_lsu_ready", 64'(lsu_ready), 64'd1);
        tick();
        rd_chk("stream_3", 1, 5'd1, 32'hA1, 3'd3);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        rd_chk("drain_1", 1, 5'd2, 32'hB2, 3'd2);
        tick();
        rd_chk("drain_2", 1, 5'd1, 32'hA1, 3'd1);
        tick();
        rd_chk("drain_3", 0, 0, 0, 0);

        // x0 handshake is dropped
        drive(1, 5'd0, 32'h55, 0, 0, 0);
        chk("x0_lsu_ready", 64'(lsu_ready), 64'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        rd_chk("x0_1", 0, 0, 0, 0);
        tick();
        rd_chk("x0_2", 0, 0, 0, 0);

        // fill to 3 then flush; head is still shown during the flush cycle
        drive(1, 5'd4, 32'h44, 1, 5'd6, 32'h66);
        tick();
        drive(1, 5'd8, 32'h88, 1, 5'd9, 32'h99);
        tick();
        rd_chk("preflush", 1, 5'd6, 32'h66, 3'd3);
        flush = 1'b1;
        drive(1, 5'd10, 32'hAA, 0, 0, 0);
        #1;
        chk("flush_lsu_ready", 64'(lsu_ready), 64'd0);
        chk("flush_alu_ready", 64'(alu_ready), 64'd0);
        chk("flush_web", 64'(rd_web), 64'd1);
        tick();
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        rd_chk("postflush", 0, 0, 0, 0);

        // reset mid-operation with flush also asserted
        drive(1, 5'd12, 32'hC0, 1, 5'd13, 32'hD0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        rd_chk("prereset", 1, 5'd12, 32'hC0, 3'd2);
        rst_n = 1'b0; flush = 1'b1;
        tick();
        rst_n = 1'b1; flush = 1'b0;
        rd_chk("midreset", 0, 0, 0, 0);

`ifdef WB_BYPASS_EN
        drive(1, 5'd7, 32'hA, 1, 5'd7, 32'hB);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        fwd_addr = 5'd7;
        #1;
        chk("fwd_hit_x7", 64'(fwd_hit), 64'd1);
        chk("fwd_data_x7", 64'(fwd_data), 64'hB);
        fwd_addr = 5'd0;
        #1;
        chk("fwd_hit_x0", 64'(fwd_hit), 64'd0);
        chk("fwd_data_x0", 64'(fwd_data), 64'd0);
        tick(); tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
